// File: rtl/ysyx_23060061_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to single-slave memory arbiter; one transaction in flight.
// Optional `ARB_ROUND_ROBIN_EN switches IFU-vs-LSU arbitration from fixed LSU priority to alternating.
module ysyx_23060061_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [31:0] m1_awaddr,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  logic [2:0] state_q, state_d;
  logic       sel_q, sel_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_q, last_d;
`endif

  logic lsu_req, grant_lsu;
  logic ar_fire, r_fire, aw_fire, w_fire;

  // Next state, grant and channel routing
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    lsu_req   = m1_awvalid | m1_arvalid;
`ifdef ARB_ROUND_ROBIN_EN
    // The master last granted yields when both sides request
    grant_lsu = lsu_req & (~m0_arvalid | ~last_q);
`else
    grant_lsu = lsu_req;
`endif
    ar_fire   = 1'b0;
    r_fire    = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;

    m0_arready = 1'b0;
    m0_rdata   = 32'h0;
    m0_rresp   = 2'b00;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = 32'h0;
    m1_rresp   = 2'b00;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = 2'b00;
    m1_bvalid  = 1'b0;
    s_araddr   = 32'h0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = 32'h0;
    s_awvalid  = 1'b0;
    s_wdata    = 32'h0;
    s_wstrb    = 4'h0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_lsu) begin
          sel_d   = 1'b1;
          state_d = m1_awvalid ? S_WR_REQ : S_RD_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = 1'b1;
`endif
        end else if (m0_arvalid) begin
          sel_d   = 1'b0;
          state_d = S_RD_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = 1'b0;
`endif
        end
      end
      S_RD_ADDR: begin
        if (sel_q) begin
          s_araddr   = m1_araddr;
          s_arvalid  = m1_arvalid;
          m1_arready = s_arready;
          ar_fire    = m1_arvalid & s_arready;
        end else begin
          s_araddr   = m0_araddr;
          s_arvalid  = m0_arvalid;
          m0_arready = s_arready;
          ar_fire    = m0_arvalid & s_arready;
        end
        if (ar_fire) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (sel_q) begin
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
          r_fire    = s_rvalid & m1_rready;
        end else begin
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
          r_fire    = s_rvalid & m0_rready;
        end
        if (r_fire) state_d = S_IDLE;
      end
      S_WR_REQ: begin
        // A channel already accepted is hidden from both sides until the pair completes
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid & ~aw_done_q;
        m1_awready = s_awready & ~aw_done_q;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid & ~w_done_q;
        m1_wready  = s_wready & ~w_done_q;
        aw_fire    = m1_awvalid & ~aw_done_q & s_awready;
        w_fire     = m1_wvalid & ~w_done_q & s_wready;
        if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_RESP;
        end else begin
          aw_done_d = aw_done_q | aw_fire;
          w_done_d  = w_done_q | w_fire;
        end
      end
      S_WR_RESP: begin
        m1_bresp  = s_bresp;
        m1_bvalid = s_bvalid;
        s_bready  = m1_bready;
        if (s_bvalid & m1_bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: doc/ysyx_23060061_mem_arbiter.md
# ysyx_23060061_mem_arbiter

Shared-memory arbiter placed between the two CPU bus masters and the single memory slave port. Master 0 is the IFU (read-only); master 1 is the LSU (read and write). The arbiter serializes all traffic, so exactly one single-beat transaction is outstanding on the slave at any time, and routes each response back to the master that issued the request.

## Interface
- No parameters; all widths fixed: address 32, data 32, strobe 4, resp 2.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- m0_araddr, m0_arvalid / m0_arready  in, in / out  32, 1 / 1  IFU read-address channel
- m0_rdata, m0_rresp, m0_rvalid / m0_rready  out / in  32, 2, 1 / 1  IFU read-data channel
- m1_araddr, m1_arvalid / m1_arready  in / out  32, 1 / 1  LSU read-address channel
- m1_rdata, m1_rresp, m1_rvalid / m1_rready  out / in  32, 2, 1 / 1  LSU read-data channel
- m1_awaddr, m1_awvalid / m1_awready  in / out  32, 1 / 1  LSU write-address channel
- m1_wdata, m1_wstrb, m1_wvalid / m1_wready  in / out  32, 4, 1 / 1  LSU write-data channel
- m1_bresp, m1_bvalid / m1_bready  out / in  2, 1 / 1  LSU write-response channel
- s_araddr, s_arvalid / s_arready  out / in  32, 1 / 1  slave read address
- s_rdata, s_rresp, s_rvalid / s_rready  in / out  32, 2, 1 / 1  slave read data
- s_awaddr, s_awvalid / s_awready  out / in  32, 1 / 1  slave write address
- s_wdata, s_wstrb, s_wvalid / s_wready  out / in  32, 4, 1 / 1  slave write data
- s_bresp, s_bvalid / s_bready  in / out  2, 1 / 1  slave write response

## Operation
- Registered state: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Also `sel` (0 = IFU, 1 = LSU), `aw_done`, `w_done`, and `last` (last-granted master, used only by the round-robin option).
- IDLE arbitration, on requests m0_arvalid, m1_arvalid, m1_awvalid:
  - Priority: LSU write > LSU read > IFU read.
  - LSU write: go to WR_REQ, sel=1.
  - Read: go to RD_ADDR with sel = winner.
- RD_ADDR:
  - s_araddr = selected master's araddr; s_arvalid = its arvalid.
  - Selected master's arready = s_arready; the other master's arready = 0.
  - On s_arvalid & s_arready, go to RD_DATA.
- RD_DATA:
  - Selected master receives s_rdata, s_rresp and s_rvalid.
  - s_rready = selected master's rready.
  - On R handshake, go to IDLE.
- WR_REQ:
  - AW and W channels pass straight through from the LSU.
  - aw_done and w_done are set on their respective handshakes. Once a channel is done, its valid to the slave is masked to 0.
  - When both channels have completed (including in the same cycle), clear both flags and go to WR_RESP.
- WR_RESP: B channel passes through to the LSU. On B handshake, go to IDLE.
- rresp and bresp are forwarded unmodified.
- Unselected masters see all ready/valid outputs at 0.
- Data and address outputs to non-selected destinations are don't-care; they are driven 0.

## Timing
- Reset values: state=IDLE, sel=0, last=0 (IFU), aw_done=0, w_done=0. All valid/ready outputs are 0 in IDLE.
- Grant is registered. A request seen in IDLE at cycle N appears on the slave at cycle N+1.
  - Minimum read: 3 cycles (IDLE, RD_ADDR, RD_DATA), with a zero-wait slave.
  - Minimum write: 3 cycles (IDLE, WR_REQ, WR_RESP), with AW and W accepted together.
- Back-to-back: return to IDLE costs one bubble cycle between transactions.
- Masters must hold valid and payload stable until ready. The arbiter never drops a request that has been granted.
- Simultaneous IFU and LSU read requests: the LSU wins under fixed priority. The IFU is served in the next IDLE, provided no new LSU request is pending.
- If a master deasserts valid in RD_ADDR (protocol violation), the state holds in RD_ADDR. No recovery logic is provided.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. The in-flight transaction is abandoned; the slave is reset by the same rst.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - IFU-vs-LSU arbitration alternates. The master with `last` equal to its index has lower priority when both request.
  - Within the LSU, write still beats read.
  - `last` updates to the winner on every grant.
- Undefined: fixed priority as above; the `last` register is absent.

## Test plan
- IFU reads 0x80000000, slave returns 0x00000413 with zero wait → m0_rdata=0x00000413, rresp=0 on cycle 3; m1 channels stay idle.
- IFU and LSU arvalid in the same IDLE cycle (addrs 0x80000004 and 0x80001000) → LSU granted first, IFU granted immediately after; with ARB_ROUND_ROBIN_EN and last=1, IFU first.
- LSU write 0xDEADBEEF, wstrb=0xF, slave accepts AW at cycle 1 and W at cycle 3 → wvalid masked after acceptance, single B returned to LSU, bresp=0.
- Slave rresp=2 on an LSU read → m1_rresp=2 forwarded; arbiter returns to IDLE normally.
- Slave stalls s_rvalid 5 cycles while IFU holds arvalid for the next fetch → no second AR issued until the R handshake completes.
- rst=0 asserted during RD_DATA → next cycle IDLE, all valid/ready outputs 0, a fresh read completes afterwards.
